// File: rtl/d16_uart.sv
// d16_uart: memory-mapped 8N1 UART for the d16 core (DATA/STATUS/CTRL/BAUD registers).
// Define D16_UART_FIFO_EN for 8-deep TX/RX FIFOs; otherwise each direction has one holding register.

module d16_uart_fifo #(
    parameter bit PUSH_ON_POP = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_push,
    input  logic [7:0] i_din,
    input  logic       i_pop,
    output logic [7:0] o_dout,
    output logic       o_empty,
    output logic       o_full
);
    logic w_pop;
    logic w_push;

    assign w_pop  = i_pop && !o_empty;
    // PUSH_ON_POP lets a push into a full store succeed when a pop frees a slot in the same cycle.
    assign w_push = i_push && (!o_full || (PUSH_ON_POP && w_pop));

`ifdef D16_UART_FIFO_EN
    logic [7:0] r_mem [0:7];
    logic [2:0] r_wptr;
    logic [2:0] r_rptr;
    logic [3:0] r_count;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wptr  <= 3'd0;
            r_rptr  <= 3'd0;
            r_count <= 4'd0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 3'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 3'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rptr];
    assign o_empty = (r_count == 4'd0);
    assign o_full  = (r_count == 4'd8);
`else
    logic [7:0] r_hold;
    logic       r_valid;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_hold  <= 8'h00;
            r_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_hold  <= i_din;
                r_valid <= 1'b1;
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_dout  = r_hold;
    assign o_empty = !r_valid;
    assign o_full  = r_valid;
`endif
endmodule

module d16_uart #(
    parameter logic [15:0] BASE_ADDR = 16'hFF00,
    parameter logic [15:0] DIV_RESET = 16'd103
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [15:0] i_wb_addr,
    input  logic        i_wb_cyc,
    input  logic        i_wb_we,
    input  logic [15:0] i_wb_dat,
    output logic [15:0] o_wb_dat,
    input  logic        i_rx,
    output logic        o_tx,
    output logic        o_int
);
    typedef enum logic [1:0] {
        TX_IDLE, TX_START, TX_DATA, TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_t;

    // Bus decode
    logic        w_sel;
    logic        w_rd;
    logic        w_wr;
    logic [1:0]  w_off;
    logic        w_rx_pop;
    logic        w_tx_push;
    logic        w_stat_wr;

    // Control / status
    logic [1:0]  r_ctrl;
    logic [15:0] r_baud;
    logic [15:0] w_div;
    logic        r_overrun;
    logic        r_frame_err;
    logic        r_int;
    logic        w_tx_idle;

    // Storage
    logic [7:0]  w_tx_dout;
    logic        w_tx_empty;
    logic        w_tx_full;
    logic [7:0]  w_rx_dout;
    logic        w_rx_empty;
    logic        w_rx_full;

    // TX
    tx_state_t   r_tx_state;
    tx_state_t   w_tx_state_next;
    logic [15:0] r_tx_cnt;
    logic [15:0] w_tx_cnt_next;
    logic [7:0]  r_tx_shift;
    logic [7:0]  w_tx_shift_next;
    logic [2:0]  r_tx_bit;
    logic [2:0]  w_tx_bit_next;
    logic        r_tx;
    logic        w_tx_next;
    logic        w_tx_pop;

    // RX
    logic        r_rx_meta;
    logic        r_rx_sync;
    logic        r_rx_prev;
    rx_state_t   r_rx_state;
    rx_state_t   w_rx_state_next;
    logic [15:0] r_rx_cnt;
    logic [15:0] w_rx_cnt_next;
    logic [7:0]  r_rx_shift;
    logic [7:0]  w_rx_shift_next;
    logic [2:0]  r_rx_bit;
    logic [2:0]  w_rx_bit_next;
    logic        w_rx_push;
    logic        w_frame_set;
    logic        w_overrun_set;

    assign w_sel     = i_wb_cyc && (i_wb_addr[15:2] == BASE_ADDR[15:2]);
    assign w_rd      = w_sel && !i_wb_we;
    assign w_wr      = w_sel && i_wb_we;
    assign w_off     = i_wb_addr[1:0];
    assign w_rx_pop  = w_rd && (w_off == 2'd0) && !w_rx_empty;
    assign w_tx_push = w_wr && (w_off == 2'd0);
    assign w_stat_wr = w_wr && (w_off == 2'd1);

    // Very small divisors cannot leave room for the half-bit RX sample.
    assign w_div     = (r_baud < 16'd3) ? 16'd3 : r_baud;
    assign w_tx_idle = (r_tx_state == TX_IDLE) && w_tx_empty;

    d16_uart_fifo #(.PUSH_ON_POP(1'b0)) u_tx_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (w_tx_push),
        .i_din     (i_wb_dat[7:0]),
        .i_pop     (w_tx_pop),
        .o_dout    (w_tx_dout),
        .o_empty   (w_tx_empty),
        .o_full    (w_tx_full)
    );

    d16_uart_fifo #(.PUSH_ON_POP(1'b1)) u_rx_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (w_rx_push),
        .i_din     (r_rx_shift),
        .i_pop     (w_rx_pop),
        .o_dout    (w_rx_dout),
        .o_empty   (w_rx_empty),
        .o_full    (w_rx_full)
    );

    always_comb begin
        o_wb_dat = 16'h0000;
        if (w_rd) begin
            case (w_off)
                2'd0: o_wb_dat = w_rx_empty ? 16'h0000 : {8'h00, w_rx_dout};
                2'd1: o_wb_dat = {11'd0, r_frame_err, r_overrun, w_tx_idle, w_tx_full, !w_rx_empty};
                2'd2: o_wb_dat = {14'd0, r_ctrl};
                2'd3: o_wb_dat = r_baud;
            endcase
        end
    end

    assign w_overrun_set = w_rx_push && w_rx_full && !w_rx_pop;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ctrl      <= 2'b00;
            r_baud      <= DIV_RESET;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            r_int       <= 1'b0;
        end else begin
            if (w_wr && (w_off == 2'd2)) begin
                r_ctrl <= i_wb_dat[1:0];
            end
            if (w_wr && (w_off == 2'd3)) begin
                r_baud <= i_wb_dat;
            end
            // A new event in the same cycle as a W1C clear wins, so it is never lost.
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (w_stat_wr && i_wb_dat[3]) begin
                r_overrun <= 1'b0;
            end
            if (w_frame_set) begin
                r_frame_err <= 1'b1;
            end else if (w_stat_wr && i_wb_dat[4]) begin
                r_frame_err <= 1'b0;
            end
            r_int <= (r_ctrl[0] && !w_rx_empty) || (r_ctrl[1] && w_tx_idle);
        end
    end

    assign o_int = r_int;
    assign o_tx  = r_tx;

    // TX: r_tx_cnt counts down the current bit; the divisor is reloaded only at bit boundaries.
    always_comb begin
        w_tx_state_next = r_tx_state;
        w_tx_cnt_next   = r_tx_cnt;
        w_tx_shift_next = r_tx_shift;
        w_tx_bit_next   = r_tx_bit;
        w_tx_next       = r_tx;
        w_tx_pop        = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_next = 1'b1;
                if (!w_tx_empty) begin
                    w_tx_pop        = 1'b1;
                    w_tx_shift_next = w_tx_dout;
                    w_tx_cnt_next   = w_div;
                    w_tx_state_next = TX_START;
                    w_tx_next       = 1'b0;
                end
            end
            TX_START: begin
                if (r_tx_cnt != 16'd0) begin
                    w_tx_cnt_next = r_tx_cnt - 16'd1;
                end else begin
                    w_tx_cnt_next   = w_div;
                    w_tx_bit_next   = 3'd0;
                    w_tx_state_next = TX_DATA;
                    w_tx_next       = r_tx_shift[0];
                end
            end
            TX_DATA: begin
                if (r_tx_cnt != 16'd0) begin
                    w_tx_cnt_next = r_tx_cnt - 16'd1;
                end else begin
                    w_tx_cnt_next   = w_div;
                    w_tx_shift_next = {1'b0, r_tx_shift[7:1]};
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_next = TX_STOP;
                        w_tx_next       = 1'b1;
                    end else begin
                        w_tx_bit_next = r_tx_bit + 3'd1;
                        w_tx_next     = r_tx_shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (r_tx_cnt != 16'd0) begin
                    w_tx_cnt_next = r_tx_cnt - 16'd1;
                end else if (!w_tx_empty) begin
                    w_tx_pop        = 1'b1;
                    w_tx_shift_next = w_tx_dout;
                    w_tx_cnt_next   = w_div;
                    w_tx_state_next = TX_START;
                    w_tx_next       = 1'b0;
                end else begin
                    w_tx_state_next = TX_IDLE;
                    w_tx_next       = 1'b1;
                end
            end
            default: w_tx_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= 16'd0;
            r_tx_shift <= 8'h00;
            r_tx_bit   <= 3'd0;
            r_tx       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_next;
            r_tx_cnt   <= w_tx_cnt_next;
            r_tx_shift <= w_tx_shift_next;
            r_tx_bit   <= w_tx_bit_next;
            r_tx       <= w_tx_next;
        end
    end

    // RX: start is detected on a falling edge of the synchronized line, then sampled mid-bit.
    always_comb begin
        w_rx_state_next = r_rx_state;
        w_rx_cnt_next   = r_rx_cnt;
        w_rx_shift_next = r_rx_shift;
        w_rx_bit_next   = r_rx_bit;
        w_rx_push       = 1'b0;
        w_frame_set     = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (r_rx_prev && !r_rx_sync) begin
                    w_rx_cnt_next   = w_div >> 1;
                    w_rx_state_next = RX_START;
                end
            end
            RX_START: begin
                if (r_rx_cnt != 16'd0) begin
                    w_rx_cnt_next = r_rx_cnt - 16'd1;
                end else if (r_rx_sync) begin
                    w_rx_state_next = RX_IDLE;
                end else begin
                    w_rx_cnt_next   = w_div;
                    w_rx_bit_next   = 3'd0;
                    w_rx_state_next = RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt != 16'd0) begin
                    w_rx_cnt_next = r_rx_cnt - 16'd1;
                end else begin
                    w_rx_cnt_next   = w_div;
                    w_rx_shift_next = {r_rx_sync, r_rx_shift[7:1]};
                    if (r_rx_bit == 3'd7) begin
                        w_rx_state_next = RX_STOP;
                    end else begin
                        w_rx_bit_next = r_rx_bit + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (r_rx_cnt != 16'd0) begin
                    w_rx_cnt_next = r_rx_cnt - 16'd1;
                end else begin
                    w_rx_push       = r_rx_sync;
                    w_frame_set     = !r_rx_sync;
                    w_rx_state_next = RX_IDLE;
                end
            end
            default: w_rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= 16'd0;
            r_rx_shift <= 8'h00;
            r_rx_bit   <= 3'd0;
        end else begin
            r_rx_meta  <= i_rx;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_rx_state <= w_rx_state_next;
            r_rx_cnt   <= w_rx_cnt_next;
            r_rx_shift <= w_rx_shift_next;
            r_rx_bit   <= w_rx_bit_next;
        end
    end
endmodule

// File: tb/tb_d16_uart.sv
// Directed bench for d16_uart: register access, TX framing, RX, errors, interrupts, reset.
module tb_d16_uart;
    localparam logic [15:0] A_DATA = 16'hFF00;
    localparam logic [15:0] A_STAT = 16'hFF01;
    localparam logic [15:0] A_CTRL = 16'hFF02;
    localparam logic [15:0] A_BAUD = 16'hFF03;
`ifdef D16_UART_FIFO_EN
    localparam int RX_DEPTH = 8;
`else
    localparam int RX_DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr;
    logic        cyc;
    logic        we;
    logic [15:0] wdat;
    logic [15:0] rdat;
    logic        rx;
    logic        tx;
    logic        intr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    d16_uart dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_wb_addr (addr),
        .i_wb_cyc  (cyc),
        .i_wb_we   (we),
        .i_wb_dat  (wdat),
        .o_wb_dat  (rdat),
        .i_rx      (rx),
        .o_tx      (tx),
        .o_int     (intr)
    );

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        addr = a; wdat = d; cyc = 1'b1; we = 1'b1;
        @(posedge clk); #1;
        cyc = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        addr = a; cyc = 1'b1; we = 1'b0;
        @(negedge clk);
        d = rdat;
        @(posedge clk); #1;
        cyc = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        for (int i = 0; i < 10; i++) begin
            rx = (i == 0) ? 1'b0 : (i == 9) ? stop_bit : b[i-1];
            repeat (4) @(posedge clk);
            #1;
        end
        rx = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        rst_n = 1'b0; cyc = 1'b0; we = 1'b0; addr = 16'h0; wdat = 16'h0; rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
        n_tests++;
        if (intr !== 1'b0) begin n_fail++; $display("FAIL reset_int: got %b expected 0", intr); end
        bus_read(A_STAT, d);
        n_tests++;
        if (d !== 16'h0004) begin n_fail++; $display("FAIL reset_status: got %h expected 0004", d); end
        bus_read(A_BAUD, d);
        n_tests++;
        if (d !== 16'd103) begin n_fail++; $display("FAIL reset_baud: got %h expected 0067", d); end
        bus_read(A_CTRL, d);
        n_tests++;
        if (d !== 16'h0000) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 0000", d); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus_read(A_DATA, d);
        n_tests++;
        if (d !== 16'h0000) begin n_fail++; $display("FAIL reset_data_empty: got %h expected 0000", d); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_tx();
        logic [15:0] d;
        logic [7:0]  b;
        logic        found;
        logic        exp;
        int          k;
        b = 8'hA5;
        bus_write(A_BAUD, 16'd3);
        bus_write(A_DATA, 16'h00A5);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (tx === 1'b0) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++; $display("FAIL tx_start_timeout: got no start bit expected start within 20 clocks");
        end else begin
            for (int j = 0; j < 40; j++) begin
                k = j / 4;
                exp = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
                n_tests++;
                if (tx !== exp) begin
                    n_fail++; $display("FAIL tx_bit clk %0d: got %b expected %b", j, tx, exp);
                end
                @(negedge clk);
            end
        end
        @(posedge clk); #1;
        bus_read(A_STAT, d);
        n_tests++;
        if (d !== 16'h0004) begin n_fail++; $display("FAIL tx_idle_after: got %h expected 0004", d); end
        $display("[TB] test_tx frame A5 done");
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        logic [7:0]  b;
        logic        found;
        logic        exp;
        int          k;
        found = 1'b0;
        fork
            begin
                bus_write(A_DATA, 16'h0001);
                @(posedge clk); #1;
                bus_write(A_DATA, 16'h0080);
            end
            begin
                for (int i = 0; i < 20 && !found; i++) begin
                    @(negedge clk);
                    if (tx === 1'b0) found = 1'b1;
                end
                n_tests++;
                if (!found) begin
                    n_fail++; $display("FAIL b2b_start_timeout: got no start bit expected start within 20 clocks");
                end else begin
                    for (int j = 0; j < 80; j++) begin
                        b = (j < 40) ? 8'h01 : 8'h80;
                        k = (j % 40) / 4;
                        exp = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
                        n_tests++;
                        if (tx !== exp) begin
                            n_fail++; $display("FAIL b2b_bit clk %0d: got %b expected %b", j, tx, exp);
                        end
                        @(negedge clk);
                    end
                end
            end
        join
        repeat (5) @(posedge clk);
        #1;
        bus_read(A_STAT, d);
        n_tests++;
        if (d !== 16'h0004) begin n_fail++; $display("FAIL b2b_idle_after: got %h expected 0004", d); end
        $display("[TB] test_back_to_back 01,80 done");
    endtask

    task automatic test_rx();
        logic [15:0] d;
        send_rx(8'h3C, 1'b1);
        bus_read(A_STAT, d);
        n_tests++;
        if (d !== 16'h0005) begin n_fail++; $display("FAIL rx_avail: got %h expected 0005", d); end
        bus_read(A_DATA, d);
        n_tests++;
        if (d !== 16'h003C) begin n_fail++; $display("FAIL rx_data: got %h expected 003C", d); end
        bus_read(A_STAT, d);
        n_tests++;
        if (d !== 16'h0004) begin n_fail++; $display("FAIL rx_avail_clear: got %h expected 0004", d); end
        $display("[TB] test_rx byte 3C done");
    endtask

    task automatic test_frame_glitch();
        logic [15:0] d;
        send_rx(8'h55, 1'b0);
        bus_read(A_STAT, d);
        n_tests++;
        if (d !== 16'h0014) begin n_fail++; $display("FAIL frame_err_set: got %h expected 0014", d); end
        bus_write(A_STAT, 16'h0010);
        bus_read(A_STAT, d);
        n_tests++;
        if (d !== 16'h0004) begin n_fail++; $display("FAIL frame_err_w1c: got %h expected 0004", d); end
        rx = 1'b0;
        @(posedge clk); #1;
        rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        bus_read(A_STAT, d);
        n_tests++;
        if (d !== 16'h0004) begin n_fail++; $display("FAIL glitch_status: got %h expected 0004", d); end
        bus_read(A_DATA, d);
        n_tests++;
        if (d !== 16'h0000) begin n_fail++; $display("FAIL glitch_data: got %h expected 0000", d); end
        $display("[TB] test_frame_glitch done");
    endtask

    task automatic test_overrun();
        logic [15:0] d;
        logic [15:0] exp;
        for (int i = 0; i < 9; i++) begin
            send_rx(8'h10 + 8'(i), 1'b1);
        end
        bus_read(A_STAT, d);
        n_tests++;
        if (d !== 16'h000D) begin n_fail++; $display("FAIL overrun_set: got %h expected 000D", d); end
        for (int i = 0; i < RX_DEPTH; i++) begin
            exp = 16'h0010 + 16'(i);
            bus_read(A_DATA, d);
            n_tests++;
            if (d !== exp) begin n_fail++; $display("FAIL overrun_order %0d: got %h expected %h", i, d, exp); end
        end
        bus_read(A_STAT, d);
        n_tests++;
        if (d !== 16'h000C) begin n_fail++; $display("FAIL overrun_drained: got %h expected 000C", d); end
        bus_write(A_STAT, 16'h0008);
        bus_read(A_STAT, d);
        n_tests++;
        if (d !== 16'h0004) begin n_fail++; $display("FAIL overrun_w1c: got %h expected 0004", d); end
        $display("[TB] test_overrun depth %0d done", RX_DEPTH);
    endtask

    task automatic test_int();
        logic [15:0] d;
        logic        prev;
        logic        seen;
        bus_write(A_CTRL, 16'h0001);
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (intr !== 1'b0) begin n_fail++; $display("FAIL int_idle_rx: got %b expected 0", intr); end
        addr = A_STAT; cyc = 1'b1; we = 1'b0;
        seen = 1'b0;
        prev = 1'b0;
        fork
            send_rx(8'h5A, 1'b1);
            begin
                @(negedge clk);
                prev = rdat[0];
                for (int i = 0; i < 70; i++) begin
                    @(negedge clk);
                    n_tests++;
                    if (intr !== prev) begin
                        n_fail++; $display("FAIL int_delay clk %0d: got %b expected %b", i, intr, prev);
                    end
                    if (rdat[0]) seen = 1'b1;
                    prev = rdat[0];
                end
            end
        join
        @(posedge clk); #1;
        cyc = 1'b0;
        n_tests++;
        if (seen !== 1'b1) begin n_fail++; $display("FAIL int_rx_seen: got %b expected 1", seen); end
        bus_read(A_DATA, d);
        n_tests++;
        if (d !== 16'h005A) begin n_fail++; $display("FAIL int_rx_data: got %h expected 005A", d); end
        bus_write(A_CTRL, 16'h0002);
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (intr !== 1'b1) begin n_fail++; $display("FAIL int_tx_idle: got %b expected 1", intr); end
        bus_write(A_CTRL, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (intr !== 1'b0) begin n_fail++; $display("FAIL int_disabled: got %b expected 0", intr); end
        $display("[TB] test_int done");
    endtask

    task automatic test_baud_min();
        logic [15:0] d;
        logic        found;
        int          cnt;
        bus_write(A_BAUD, 16'h0000);
        bus_read(A_BAUD, d);
        n_tests++;
        if (d !== 16'h0000) begin n_fail++; $display("FAIL baud_raw: got %h expected 0000", d); end
        bus_write(A_DATA, 16'h00FF);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (tx === 1'b0) found = 1'b1;
        end
        cnt = 0;
        while (found && tx === 1'b0 && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        n_tests++;
        if (cnt != 4) begin n_fail++; $display("FAIL baud_min_start_len: got %0d expected 4", cnt); end
        repeat (50) @(posedge clk);
        #1;
        bus_write(A_BAUD, 16'd3);
        $display("[TB] test_baud_min done");
    endtask

    task automatic test_reset_mid_tx();
        logic [15:0] d;
        send_rx(8'h77, 1'b1);
        bus_write(A_CTRL, 16'h0001);
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (intr !== 1'b1) begin n_fail++; $display("FAIL rst_pre_int: got %b expected 1", intr); end
        bus_write(A_DATA, 16'h0000);
        repeat (12) @(posedge clk);
        #3;
        n_tests++;
        if (tx !== 1'b0) begin n_fail++; $display("FAIL rst_pre_tx: got %b expected 0", tx); end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL rst_async_tx: got %b expected 1", tx); end
        n_tests++;
        if (intr !== 1'b0) begin n_fail++; $display("FAIL rst_async_int: got %b expected 0", intr); end
        bus_read(A_STAT, d);
        n_tests++;
        if (d !== 16'h0004) begin n_fail++; $display("FAIL rst_status: got %h expected 0004", d); end
        bus_read(A_BAUD, d);
        n_tests++;
        if (d !== 16'd103) begin n_fail++; $display("FAIL rst_baud: got %h expected 0067", d); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus_read(A_CTRL, d);
        n_tests++;
        if (d !== 16'h0000) begin n_fail++; $display("FAIL rst_ctrl: got %h expected 0000", d); end
        $display("[TB] test_reset_mid_tx done");
    endtask

    initial begin
        test_reset();
        test_tx();
        test_back_to_back();
        test_rx();
        test_frame_glitch();
        test_overrun();
        test_int();
        test_baud_min();
        test_reset_mid_tx();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
